inst_rom_arbiter: RTL

//  Shares the single read port of the synchronous instruction ROM between two requesters:

---
 rtl/inst_rom_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/inst_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : inst_rom_arbiter
// Description : Shares the single read port of a synchronous instruction ROM
//               between instruction fetch (port 0, preferred) and a data/debug
//               read port (port 1). A starvation counter forces a port-1 win
//               after MAX_WAIT cycles of waiting under contention. Responses
//               return with fixed one-cycle latency. A misaligned or
//               out-of-range address is still granted, but it returns an
//               error response.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_rom_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_WAIT   = 4
) (
    input  logic        clock,
    input  logic        reset,
    // fetch port (port 0)
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    // data/debug port (port 1)
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    // ROM interface
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    // shared response
    output logic [31:0] rd_data,
    output logic        rd_err,
    output logic [2:0]  starve_cnt
);

    localparam logic [2:0] c_max_wait = 3'(MAX_WAIT);
    localparam int         c_hi_shift = ADDR_WIDTH + 2;

    // Response pipeline: one request in flight at most.
    logic        r_valid;
    logic        r_port;      // 0 = fetch, 1 = data
    logic        r_err;
    logic [2:0]  r_starve;
    logic [31:0] r_addr_hold;

    logic        w_f_win;
    logic        w_d_win;
    logic [31:0] w_win_addr;
    logic        w_win_err;

    // Arbitration: fetch wins unless the data port has waited MAX_WAIT cycles.
    always_comb begin
        w_f_win = 1'b0;
        w_d_win = 1'b0;
        if (!reset) begin
            if (f_req && d_req) begin
                if (r_starve == c_max_wait) begin
                    w_d_win = 1'b1;
                end else begin
                    w_f_win = 1'b1;
                end
            end else begin
                w_f_win = f_req;
                w_d_win = d_req;
            end
        end
    end

    // Winner address and error classification (misaligned or beyond ROM range).
    always_comb begin
        w_win_addr = d_win_sel() ? d_addr : f_addr;
        w_win_err  = (w_win_addr[1:0] != 2'b00) ||
                     ((w_win_addr >> c_hi_shift) != 32'd0);
    end

    function automatic logic d_win_sel();
        return w_d_win;
    endfunction

    // Grants and ROM address: winner's raw address, else the held value.
    always_comb begin
        f_gnt = w_f_win;
        d_gnt = w_d_win;
        if (reset) begin
            rom_addr = 32'd0;
        end else if (w_f_win || w_d_win) begin
            rom_addr = w_win_addr;
        end else begin
            rom_addr = r_addr_hold;
        end
    end

    // Capture valid/port/error tags for the response cycle and hold the ROM address.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_port      <= 1'b0;
            r_err       <= 1'b0;
            r_addr_hold <= 32'd0;
        end else begin
            r_valid <= w_f_win || w_d_win;
            if (w_f_win || w_d_win) begin
                r_port      <= w_d_win;
                r_err       <= w_win_err;
                r_addr_hold <= w_win_addr;
            end
        end
    end

    // Starvation counter: counts data-port cycles spent waiting, saturating at MAX_WAIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_starve <= 3'd0;
        end else if (d_req && !w_d_win) begin
            if (r_starve != c_max_wait) begin
                r_starve <= r_starve + 3'd1;
            end
        end else begin
            r_starve <= 3'd0;
        end
    end

    // Response outputs: suppressed while reset is asserted so no stale strobe escapes.
    always_comb begin
        f_rvalid   = r_valid && !r_port && !reset;
        d_rvalid   = r_valid &&  r_port && !reset;
        rd_err     = r_valid &&  r_err  && !reset;
        rd_data    = r_err ? 32'd0 : rom_data;
        starve_cnt = r_starve;
    end

endmodule
`default_nettype wire
